emac_rx_driver: RTL

- Synthesizable EMAC-side source for the EMAC RX client interface: takes frames from an internal byte stream and drives DATA/DVLD/GOODFRAME/BADFRAME/FRAMEDROP/STATS* exactly as the EMAC core would present them to a client.
- Store-and-forward: each frame is buffered whole, then emitted with DVLD held high continuously. The EMAC RX interface has no backpressure, so DVLD cannot have gaps inside a frame.
- Used as a loopback/traffic source in front of RX client logic, and as the reference driver for RX-path verification.

---
 rtl/emac_rx_driver.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/emac_rx_driver.sv
`default_nettype none
// ============================================================================
// Module   : emac_rx_driver
// Brief    : Store-and-forward source that replays buffered frames on the
//            EMAC RX client interface (DATA/DVLD, status pulses, stats).
// Revision : 1.0  initial release
// ============================================================================
module emac_rx_driver #(
  parameter int BUF_DEPTH = 2048,
  parameter int IFG       = 12
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] IN_DATA,
  input  logic       IN_SOF,
  input  logic       IN_EOF,
  input  logic       IN_ERR,
  input  logic       IN_VLD,
  output logic       IN_RDY,
  output logic [7:0] DATA,
  output logic       DVLD,
  output logic       GOODFRAME,
  output logic       BADFRAME,
  output logic       FRAMEDROP,
  output logic [6:0] STATS,
  output logic       STATSVLD,
  output logic       STATSBYTEVLD
);

  localparam int            c_AW       = $clog2(BUF_DEPTH);
  localparam logic [c_AW:0] c_FULL_LEN = BUF_DEPTH[c_AW:0];
  localparam int            c_IFG_M1   = IFG - 1;
  localparam logic [7:0]    c_IFG_LAST = c_IFG_M1[7:0];

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_FULL, W_DROP} wstate_t;
  typedef enum logic [2:0] {R_IDLE, R_DATA, R_STATUS, R_STATS, R_GAP} rstate_t;

  wstate_t         r_wstate, w_wstate_nxt;
  logic [c_AW:0]   r_len, w_len_nxt;
  logic            r_err, w_err_nxt;
  logic            w_we;
  logic [c_AW-1:0] w_waddr;
  logic            w_drop;
  logic            w_acc;
  logic [7:0]      r_mem [BUF_DEPTH];

  rstate_t         r_rstate, w_rstate_nxt;
  logic [c_AW-1:0] r_raddr, w_raddr_nxt;
  logic [c_AW:0]   r_rlen, w_rlen_nxt;
  logic            r_rerr, w_rerr_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic            w_rd_last;
  logic [13:0]     w_len14;
  logic [27:0]     w_vec;
  logic [6:0]      w_chunk;

  logic [7:0]      r_data;
  logic            r_dvld, r_good, r_bad, r_drop, r_statsvld;
  logic [6:0]      r_stats;

  assign w_acc     = IN_VLD && (r_wstate != W_FULL);
  assign w_rd_last = (r_rstate == R_DATA) && ({1'b0, r_raddr} == (r_rlen - 1'b1));

  // ---------------- writer ----------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wstate <= W_IDLE;
      r_len    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_len    <= w_len_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_len_nxt    = r_len;
    w_err_nxt    = r_err;
    w_we         = 1'b0;
    w_waddr      = r_len[c_AW-1:0];
    w_drop       = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_acc && IN_SOF) begin
          w_we         = 1'b1;
          w_waddr      = '0;
          w_len_nxt    = {{c_AW{1'b0}}, 1'b1};
          w_err_nxt    = IN_ERR;
          w_wstate_nxt = IN_EOF ? W_FULL : W_FILL;
        end
      end
      W_FILL: begin
        if (w_acc) begin
          if (IN_SOF) begin
            // A fresh SOF abandons the partial frame and restarts at byte 0
            w_we         = 1'b1;
            w_waddr      = '0;
            w_len_nxt    = {{c_AW{1'b0}}, 1'b1};
            w_err_nxt    = IN_ERR;
            w_wstate_nxt = IN_EOF ? W_FULL : W_FILL;
          end else if (r_len == c_FULL_LEN) begin
            if (IN_EOF) begin
              w_drop       = 1'b1;
              w_wstate_nxt = W_IDLE;
            end else begin
              w_wstate_nxt = W_DROP;
            end
          end else begin
            w_we      = 1'b1;
            w_len_nxt = r_len + 1'b1;
            if (IN_EOF) begin
              w_err_nxt    = IN_ERR;
              w_wstate_nxt = W_FULL;
            end
          end
        end
      end
      W_FULL: begin
        if (w_rd_last) w_wstate_nxt = W_IDLE;
      end
      W_DROP: begin
        if (w_acc && IN_EOF) begin
          w_drop       = 1'b1;
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_we) r_mem[w_waddr] <= IN_DATA;
  end

  // ---------------- reader ----------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rstate <= R_IDLE;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rerr   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_raddr  <= w_raddr_nxt;
      r_rlen   <= w_rlen_nxt;
      r_rerr   <= w_rerr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Length and error are copied at frame start so the writer can refill early
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_raddr_nxt  = r_raddr;
    w_rlen_nxt   = r_rlen;
    w_rerr_nxt   = r_rerr;
    w_cnt_nxt    = r_cnt;
    case (r_rstate)
      R_IDLE: begin
        if (r_wstate == W_FULL) begin
          w_rstate_nxt = R_DATA;
          w_raddr_nxt  = '0;
          w_rlen_nxt   = r_len;
          w_rerr_nxt   = r_err;
        end
      end
      R_DATA: begin
        w_raddr_nxt = r_raddr + 1'b1;
        if (w_rd_last) w_rstate_nxt = R_STATUS;
      end
      R_STATUS: begin
        w_rstate_nxt = R_STATS;
        w_cnt_nxt    = '0;
      end
      R_STATS: begin
        if (r_cnt == 8'd3) begin
          w_rstate_nxt = R_GAP;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      R_GAP: begin
        if (r_cnt == c_IFG_LAST) begin
          w_rstate_nxt = R_IDLE;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  generate
    if (c_AW + 1 >= 14) begin : g_len_trunc
      assign w_len14 = r_rlen[13:0];
    end else begin : g_len_ext
      assign w_len14 = {{(13 - c_AW){1'b0}}, r_rlen};
    end
  endgenerate

  assign w_vec = {12'd0, w_len14, r_rerr, ~r_rerr};

  always_comb begin
    case (r_cnt[1:0])
      2'd0:    w_chunk = w_vec[6:0];
      2'd1:    w_chunk = w_vec[13:7];
      2'd2:    w_chunk = w_vec[20:14];
      default: w_chunk = w_vec[27:21];
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_data     <= '0;
      r_dvld     <= 1'b0;
      r_good     <= 1'b0;
      r_bad      <= 1'b0;
      r_drop     <= 1'b0;
      r_statsvld <= 1'b0;
      r_stats    <= '0;
    end else begin
      r_data     <= (r_rstate == R_DATA) ? r_mem[r_raddr] : 8'd0;
      r_dvld     <= (r_rstate == R_DATA);
      r_good     <= (r_rstate == R_STATUS) && !r_rerr;
      r_bad      <= (r_rstate == R_STATUS) && r_rerr;
      r_drop     <= w_drop;
      r_statsvld <= (r_rstate == R_STATS);
      r_stats    <= (r_rstate == R_STATS) ? w_chunk : 7'd0;
    end
  end

  assign IN_RDY       = (r_wstate != W_FULL);
  assign DATA         = r_data;
  assign DVLD         = r_dvld;
  assign STATSBYTEVLD = r_dvld;
  assign GOODFRAME    = r_good;
  assign BADFRAME     = r_bad;
  assign FRAMEDROP    = r_drop;
  assign STATS        = r_stats;
  assign STATSVLD     = r_statsvld;

endmodule
`default_nettype wire
